// File: rtl/riscv_mc_seq.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mc_seq
// Brief    : Multi-cycle RV32I instruction sequencer. Owns the PC, the
//            instruction register and the retired-instruction counter, and
//            steps each instruction through FETCH/DECODE/EXEC/MEM/WB using
//            handshaked instruction and data memory ports. Memory waits are
//            bounded; a timeout, illegal opcode or misaligned branch target
//            parks the sequencer in a sticky FAULT state until reset.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mc_seq #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              WAIT_MAX = 15,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  input  logic             alu_zero,
  input  logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  pc,
  output logic [31:0]      instr,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic             retired,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] FC_TIMEOUT    = 2'd1;
  localparam logic [1:0] FC_ILLEGAL    = 2'd2;
  localparam logic [1:0] FC_MISALIGNED = 2'd3;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  // Last wait count at which a missing ready still leaves the request alive;
  // one more unacknowledged cycle is the WAIT_MAX-th and trips the timeout.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_e             state_q;
  logic [XLEN-1:0]    pc_q;
  logic [31:0]        instr_q;
  logic [7:0]         wait_q;
  logic [CNT_W-1:0]   instret_q;
  logic               fault_q;
  logic [1:0]         fault_code_q;
  logic               dmem_req_q;
  logic               dmem_we_q;
  logic               reg_write_q;
  logic               mem_to_reg_q;
  logic               alu_src_q;
  logic [1:0]         alu_op_q;
  logic               retired_q;

  logic               is_r;
  logic               is_i;
  logic               is_ld;
  logic               is_st;
  logic               is_br;
  logic               is_valid;
  logic [XLEN-1:0]    pc_plus4_d;
  logic [XLEN-1:0]    br_target_d;

  // Opcode classification and PC candidates, all from registered state.
  always_comb begin
    is_r        = (instr_q[6:0] == OP_R);
    is_i        = (instr_q[6:0] == OP_I);
    is_ld       = (instr_q[6:0] == OP_LOAD);
    is_st       = (instr_q[6:0] == OP_STORE);
    is_br       = (instr_q[6:0] == OP_BRANCH);
    is_valid    = is_r | is_i | is_ld | is_st | is_br;
    pc_plus4_d  = pc_q + XLEN'(4);
    br_target_d = alu_zero ? (pc_q + imm) : pc_plus4_d;
  end

  // Sequencer FSM: state, PC, IR, wait counter, counters and all strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      wait_q       <= '0;
      instret_q    <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= '0;
      retired_q    <= 1'b0;
    end else begin
      retired_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            wait_q  <= '0;
            state_q <= S_DECODE;
          end else if (wait_q >= WAIT_LAST) begin
            wait_q       <= '0;
            state_q      <= S_FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= FC_TIMEOUT;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end

        S_DECODE: begin
          if (is_valid) begin
            state_q   <= S_EXEC;
            alu_src_q <= is_i | is_ld | is_st;
            alu_op_q  <= is_br ? ALUOP_BRANCH :
                         (is_r | is_i) ? ALUOP_FUNCT : ALUOP_ADD;
          end else begin
            state_q      <= S_FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= FC_ILLEGAL;
          end
        end

        S_EXEC: begin
          if (is_br) begin
            alu_src_q <= 1'b0;
            alu_op_q  <= '0;
            if (br_target_d[1:0] != 2'b00) begin
              state_q      <= S_FAULT;
              fault_q      <= 1'b1;
              fault_code_q <= FC_MISALIGNED;
            end else begin
              pc_q      <= br_target_d;
              retired_q <= 1'b1;
              instret_q <= instret_q + CNT_W'(1);
              state_q   <= S_FETCH;
            end
          end else if (is_ld | is_st) begin
            // alu_src/alu_op keep their EXEC values so the address is stable.
            dmem_req_q <= 1'b1;
            dmem_we_q  <= is_st;
            state_q    <= S_MEM;
          end else begin
            reg_write_q <= 1'b1;
            state_q     <= S_WB;
          end
        end

        S_MEM: begin
          if (dmem_req_q && dmem_ready) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            wait_q     <= '0;
            if (is_ld) begin
              reg_write_q  <= 1'b1;
              mem_to_reg_q <= 1'b1;
              state_q      <= S_WB;
            end else begin
              alu_src_q <= 1'b0;
              alu_op_q  <= '0;
              pc_q      <= pc_plus4_d;
              retired_q <= 1'b1;
              instret_q <= instret_q + CNT_W'(1);
              state_q   <= S_FETCH;
            end
          end else if (wait_q >= WAIT_LAST) begin
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= '0;
            wait_q       <= '0;
            state_q      <= S_FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= FC_TIMEOUT;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end

        S_WB: begin
          alu_src_q <= 1'b0;
          alu_op_q  <= '0;
          pc_q      <= pc_plus4_d;
          retired_q <= 1'b1;
          instret_q <= instret_q + CNT_W'(1);
          state_q   <= S_FETCH;
        end

        S_FAULT: begin
          state_q <= S_FAULT;
        end

        default: begin
          state_q      <= S_FAULT;
          fault_q      <= 1'b1;
          fault_code_q <= FC_ILLEGAL;
        end
      endcase
    end
  end

  // The state register already reads FETCH while reset is held, so the fetch
  // request is qualified with reset to keep every strobe low during reset.
  assign imem_req   = rst & (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign reg_write  = reg_write_q;
  assign mem_to_reg = mem_to_reg_q;
  assign alu_src    = alu_src_q;
  assign alu_op     = alu_op_q;
  assign state      = state_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign retired    = retired_q;
  assign instret    = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_mc_seq
// Brief    : Self-checking bench for riscv_mc_seq. Expected PC / instret
//            pairs are queued as each instruction is issued and compared when
//            the sequencer pulses retired; direct checks cover reset, cycle
//            counts, strobes and fault handling.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mc_seq;

  localparam int XLEN     = 32;
  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = 15;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_BEQ  = 32'h00000063;
  localparam logic [31:0] I_LW   = 32'h00002083;
  localparam logic [31:0] I_SW   = 32'h00102023;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic [31:0]      imem_rdata;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ready;
  logic             alu_zero;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  pc;
  logic [31:0]      instr;
  logic             reg_write;
  logic             mem_to_reg;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic [2:0]       state;
  logic             fault;
  logic [1:0]       fault_code;
  logic             retired;
  logic [CNT_W-1:0] instret;

  riscv_mc_seq #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0),
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ready (dmem_ready),
    .alu_zero   (alu_zero),
    .imm        (imm),
    .pc         (pc),
    .instr      (instr),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .state      (state),
    .fault      (fault),
    .fault_code (fault_code),
    .retired    (retired),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      pc;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             mon_e;
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [31:0]      exp_pc;
  logic [CNT_W-1:0] exp_cnt;

  // Results of the most recent run_instr call.
  int               r_cyc, r_req, r_we, r_rw, r_m2r;
  logic             r_src;
  logic [1:0]       r_op;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every retired pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && retired) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 64'(sb_q.size()), 64'd1);
      end else begin
        mon_e = sb_q.pop_front();
        chk("ret_pc", 64'(pc), 64'(mon_e.pc));
        chk("ret_cnt", 64'(instret), 64'(mon_e.cnt));
      end
    end
  end

  // Present one instruction from FETCH and follow it until the sequencer is
  // back in FETCH or has faulted; data ready is given after dlat MEM cycles.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] immv,
                           input logic z, input int dlat);
    int mem_cnt;
    mem_cnt = 0;
    r_cyc = 0; r_req = 0; r_we = 0; r_rw = 0; r_m2r = 0;
    r_src = 1'b0; r_op = 2'b11;
    imem_rdata = ins; imm = immv; alu_zero = z; imem_ready = 1'b1;
    do begin
      if (dmem_req) begin
        r_req++;
        if (dmem_we) r_we++;
      end
      if (reg_write) begin
        r_rw++;
        if (mem_to_reg) r_m2r++;
      end
      if (state == 3'd2) begin
        r_src = alu_src;
        r_op  = alu_op;
      end
      dmem_ready = (state == 3'd3) && (mem_cnt >= dlat);
      if (state == 3'd3) mem_cnt++;
      @(negedge clk);
      r_cyc++;
    end while (state != 3'd0 && state != 3'd7 && r_cyc < 50);
    dmem_ready = 1'b0;
    if (r_cyc >= 50) chk("run_bound", 64'(r_cyc), 64'd0);
  endtask

  // Issue an instruction expected to retire; queue its expected PC/count.
  task automatic do_instr(input logic [31:0] ins, input logic [31:0] immv,
                          input logic z, input int dlat);
    exp_t e;
    if (ins[6:0] == 7'b1100011 && z) exp_pc = exp_pc + immv;
    else                             exp_pc = exp_pc + 32'd4;
    exp_cnt = exp_cnt + 1'b1;
    e.pc  = exp_pc;
    e.cnt = exp_cnt;
    sb_q.push_back(e);
    run_instr(ins, immv, z, dlat);
    chk("pc", 64'(pc), 64'(exp_pc));
  endtask

  // Asynchronous reset between clock edges, checked before any edge arrives.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_code", 64'(fault_code), 64'd0);
    chk("rst_instret", 64'(instret), 64'd0);
    chk("rst_strobes", 64'({imem_req, dmem_req, dmem_we, reg_write, retired}), 64'd0);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_pc  = 32'h0;
    exp_cnt = '0;
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    imem_rdata = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    alu_zero = 1'b0; imm = '0;
    exp_pc = '0; exp_cnt = '0;

    // Reset, then ADDI: four cycles, one reg_write, pc=4, instret=1.
    do_reset();
    do_instr(I_ADDI, 32'h5, 1'b0, 0);
    chk("addi_cyc", 64'(r_cyc), 64'd4);
    chk("addi_rw", 64'(r_rw), 64'd1);
    chk("addi_src", 64'(r_src), 64'd1);
    chk("addi_op", 64'(r_op), 64'd2);
    chk("addi_instret", 64'(instret), 64'd1);

    // R-type takes register B operand.
    do_instr(I_ADD, 32'h0, 1'b0, 0);
    chk("add_cyc", 64'(r_cyc), 64'd4);
    chk("add_src", 64'(r_src), 64'd0);
    chk("add_op", 64'(r_op), 64'd2);
    for (int i = 0; i < 2; i++) do_instr(I_ADDI, 32'h1, 1'b0, 0);

    // Taken BEQ at pc=0x10, imm=8.
    chk("beq_start_pc", 64'(pc), 64'h10);
    do_instr(I_BEQ, 32'h8, 1'b1, 0);
    chk("beq_cyc", 64'(r_cyc), 64'd3);
    chk("beq_rw", 64'(r_rw), 64'd0);
    chk("beq_req", 64'(r_req), 64'd0);
    chk("beq_op", 64'(r_op), 64'd1);
    chk("beq_src", 64'(r_src), 64'd0);

    // Not-taken BEQ falls through.
    do_instr(I_BEQ, 32'h8, 1'b0, 0);
    chk("bnt_cyc", 64'(r_cyc), 64'd3);

    // Load with immediate ready.
    do_instr(I_LW, 32'h0, 1'b0, 0);
    chk("lw_cyc", 64'(r_cyc), 64'd5);
    chk("lw_req", 64'(r_req), 64'd1);
    chk("lw_we", 64'(r_we), 64'd0);
    chk("lw_rw", 64'(r_rw), 64'd1);
    chk("lw_m2r", 64'(r_m2r), 64'd1);
    chk("lw_src", 64'(r_src), 64'd1);
    chk("lw_op", 64'(r_op), 64'd0);

    // Store with three wait cycles.
    do_instr(I_SW, 32'h0, 1'b0, 3);
    chk("sw_cyc", 64'(r_cyc), 64'd7);
    chk("sw_req", 64'(r_req), 64'd4);
    chk("sw_we", 64'(r_we), 64'd4);
    chk("sw_rw", 64'(r_rw), 64'd0);

    // PC wraps silently: branch to 0xFFFFFFFC, then one more instruction.
    do_instr(I_BEQ, 32'hFFFF_FFFC - exp_pc, 1'b1, 0);
    do_instr(I_ADDI, 32'h0, 1'b0, 0);
    chk("pc_wrap", 64'(pc), 64'h0);
    chk("wrap_fault", 64'(fault), 64'd0);

    // Retired counter wraps 15 -> 0 (CNT_W = 4).
    for (int i = 0; i < 6; i++) do_instr(I_ADDI, 32'h0, 1'b0, 0);
    chk("instret_wrap", 64'(instret), 64'd0);

    // Ready arriving in the last allowed wait cycle is accepted.
    do_reset();
    repeat (14) @(negedge clk);
    chk("late_state", 64'(state), 64'd0);
    do_instr(I_ADDI, 32'h0, 1'b0, 0);
    chk("late_cyc", 64'(r_cyc), 64'd4);
    chk("late_fault", 64'(fault), 64'd0);

    // Fetch timeout after WAIT_MAX cycles; fault is absorbing.
    do_reset();
    cnt = 0;
    while (state == 3'd0 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("to_cycles", 64'(cnt), 64'(WAIT_MAX));
    chk("to_state", 64'(state), 64'd7);
    chk("to_fault", 64'(fault), 64'd1);
    chk("to_code", 64'(fault_code), 64'd1);
    chk("to_pc", 64'(pc), 64'd0);
    imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("fault_strobes", 64'({imem_req, dmem_req, dmem_we, reg_write, retired}), 64'd0);
      chk("fault_hold", 64'(state), 64'd7);
    end
    dmem_ready = 1'b0;

    // Misaligned branch target faults with code 3, pc unchanged.
    do_reset();
    do_instr(I_ADDI, 32'h0, 1'b0, 0);
    run_instr(I_BEQ, 32'h2, 1'b1, 0);
    chk("mis_cyc", 64'(r_cyc), 64'd3);
    chk("mis_state", 64'(state), 64'd7);
    chk("mis_code", 64'(fault_code), 64'd3);
    chk("mis_pc", 64'(pc), 64'd4);
    chk("mis_instret", 64'(instret), 64'd1);

    // Data memory timeout in MEM.
    do_reset();
    run_instr(I_LW, 32'h0, 1'b0, 1000);
    chk("dto_cyc", 64'(r_cyc), 64'(3 + WAIT_MAX));
    chk("dto_code", 64'(fault_code), 64'd1);
    chk("dto_state", 64'(state), 64'd7);

    // Illegal opcode faults on the cycle after DECODE; async reset clears it.
    do_reset();
    run_instr(I_BAD, 32'h0, 1'b0, 0);
    chk("ill_cyc", 64'(r_cyc), 64'd2);
    chk("ill_state", 64'(state), 64'd7);
    chk("ill_code", 64'(fault_code), 64'd2);
    do_reset();

    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
